// File: rtl/script_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : script_sequencer
// Brief    : Fetches 16-bit script words at pc and drives the game command bus.
// Revision : 1.0
// ============================================================================
module script_sequencer #(
  parameter int PC_W     = 8,
  parameter int PC_STEP  = 2,
  parameter int WAIT_W   = 8,
  parameter int TICK_DIV = 1,
  parameter int TIMEOUT  = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go_i,
  input  logic            step_mode_i,
  input  logic            step_i,
  input  logic [15:0]     script_i,
  input  logic [7:0]      out_bits_i,
  output logic [PC_W-1:0] pc_o,
  output logic [7:0]      in_bits_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [3:0]      state_dbg_o
);

  localparam int c_to_w  = (TIMEOUT > 3) ? $clog2(TIMEOUT + 1) : 2;
  localparam int c_wt_w  = WAIT_W + $clog2(TICK_DIV + 1);
  localparam int c_cnt_w = (c_to_w > c_wt_w) ? c_to_w : c_wt_w;

  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PC_W-1:0]    c_pc_step = PC_W'(PC_STEP);

  // State codes follow the order the states are listed in, so LEDs read 0..12
  localparam logic [3:0] c_idle      = 4'd0;
  localparam logic [3:0] c_fetch     = 4'd1;
  localparam logic [3:0] c_decode    = 4'd2;
  localparam logic [3:0] c_start     = 4'd3;
  localparam logic [3:0] c_target    = 4'd4;
  localparam logic [3:0] c_move      = 4'd5;
  localparam logic [3:0] c_act       = 4'd6;
  localparam logic [3:0] c_wait_cnt  = 4'd7;
  localparam logic [3:0] c_wait_cond = 4'd8;
  localparam logic [3:0] c_advance   = 4'd9;
  localparam logic [3:0] c_hold      = 4'd10;
  localparam logic [3:0] c_done      = 4'd11;
  localparam logic [3:0] c_error     = 4'd12;

  localparam logic [4:0] c_op_start = 5'b01100;
  localparam logic [4:0] c_op_end   = 5'b10100;
  localparam logic [4:0] c_op_wait  = 5'b00011;
  localparam logic [4:0] c_op_cond  = 5'b01011;
  localparam logic [4:0] c_op_jump  = 5'b00010;

  logic [3:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [15:0]        instr_q, instr_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [7:0]         in_bits_q, in_bits_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [1:0]         w_act;
  logic               w_cond_met;
  logic               w_timeout;
  logic [WAIT_W-1:0]  w_wait_n;
  logic [c_cnt_w-1:0] w_wait_total;
  logic [c_cnt_w-1:0] w_wait_last;
  logic [PC_W-1:0]    w_jump_pc;
  logic               w_unused;

  assign w_act        = instr_q[4:3];
  assign w_wait_n     = instr_q[8 +: WAIT_W];
  assign w_wait_total = c_cnt_w'(w_wait_n) * c_cnt_w'(TICK_DIV);
  assign w_wait_last  = w_wait_total - c_cnt_w'(1);
  assign w_jump_pc    = PC_W'({24'b0, instr_q[15:8]} * 32'(PC_STEP));
  assign w_timeout    = (TIMEOUT != 0) && (cnt_q == c_to_last);
  assign w_unused     = ^{out_bits_i[7:6], out_bits_i[1:0]};

  // Exit condition of whichever feedback wait is active this cycle
  always_comb begin
    w_cond_met = 1'b0;
    case (state_q)
      c_move: w_cond_met = out_bits_i[2];
      c_act: begin
        case (w_act)
          2'b00:   w_cond_met = out_bits_i[3];
          2'b01:   w_cond_met = !out_bits_i[3];
          2'b11:   w_cond_met = !out_bits_i[3];
          default: w_cond_met = 1'b1;
        endcase
      end
      c_wait_cond: w_cond_met = out_bits_i[2 + 32'(instr_q[6:5])];
      default: w_cond_met = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_idle;
      pc_q      <= '0;
      instr_q   <= '0;
      cnt_q     <= '0;
      in_bits_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      in_bits_q <= in_bits_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      c_idle:   if (go_i) state_d = c_fetch;
      c_fetch: begin
        instr_d = script_i;
        state_d = c_decode;
      end
      c_decode: begin
        if (instr_q[2:0] == 3'b001) begin
          state_d = c_target;
        end else begin
          case (instr_q[4:0])
            c_op_start: state_d = c_start;
            c_op_end:   state_d = c_done;
            c_op_wait:  state_d = c_wait_cnt;
            c_op_cond:  state_d = instr_q[7] ? c_error : c_wait_cond;
            c_op_jump: begin
              pc_d    = w_jump_pc;
              state_d = c_fetch;
            end
            default:    state_d = c_error;
          endcase
        end
      end
      c_start:  if (cnt_q == c_cnt_w'(1)) state_d = c_advance;
      c_target: state_d = (w_act == 2'b11) ? c_act : c_move;
      c_move: begin
        if (w_cond_met)     state_d = c_act;
        else if (w_timeout) state_d = c_error;
      end
      c_act, c_wait_cond: begin
        if (w_cond_met)     state_d = c_advance;
        else if (w_timeout) state_d = c_error;
      end
      c_wait_cnt: begin
        if ((w_wait_n == '0) || (cnt_q == w_wait_last)) state_d = c_advance;
      end
      c_advance: begin
        pc_d    = pc_q + c_pc_step;
        state_d = step_mode_i ? c_hold : c_fetch;
      end
      c_hold:   if (step_i || !step_mode_i) state_d = c_fetch;
      c_done:   state_d = c_done;
      c_error:  state_d = c_error;
      default:  state_d = c_idle;
    endcase
    // One counter serves START length, WAIT_CNT length and the feedback timeout
    cnt_d = (state_d != state_q) ? '0 : cnt_q + c_cnt_w'(1);
  end

  always_comb begin
    in_bits_d = 8'h00;
    case (state_d)
      c_start:  in_bits_d = 8'b0000_0101;
      c_done:   in_bits_d = 8'b0000_1001;
      c_target: in_bits_d = {instr_q[13:8], 2'b11};
      c_move:   in_bits_d = 8'b0010_0010;
      c_act: begin
        case (w_act)
          2'b00:   in_bits_d = 8'b0000_0110;
          2'b01:   in_bits_d = 8'b0000_1010;
          2'b10:   in_bits_d = 8'b0001_0010;
          default: in_bits_d = 8'b0100_0010;
        endcase
      end
      default:  in_bits_d = 8'h00;
    endcase
    busy_d = (state_d != c_idle) && (state_d != c_done) && (state_d != c_error);
    done_d = done_q | (state_d == c_done);
    err_d  = err_q  | (state_d == c_error);
  end

  assign pc_o        = pc_q;
  assign in_bits_o   = in_bits_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_dbg_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_script_sequencer.sv
`default_nettype none
// Directed bench for script_sequencer with TICK_DIV=4 and TIMEOUT=10.
module tb_script_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        step_mode;
  logic        step;
  logic [15:0] script;
  logic [7:0]  out_bits;
  logic [7:0]  pc;
  logic [7:0]  in_bits;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  state_dbg;

  logic [15:0] rom [256];
  int total = 0;
  int bad   = 0;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_MOVE = 4'd5, S_WAIT_CNT = 4'd7,
                         S_WAIT_COND = 4'd8, S_HOLD = 4'd10, S_DONE = 4'd11, S_ERROR = 4'd12;

  assign script = rom[pc];

  script_sequencer #(
    .PC_W(8), .PC_STEP(2), .WAIT_W(8), .TICK_DIV(4), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst), .go_i(go), .step_mode_i(step_mode), .step_i(step),
    .script_i(script), .out_bits_i(out_bits), .pc_o(pc), .in_bits_o(in_bits),
    .busy_o(busy), .done_o(done), .err_o(err), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0014;
  endtask

  task automatic do_reset;
    rst = 1'b1; go = 1'b0; step = 1'b0; step_mode = 1'b0; out_bits = 8'h00;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rom_clear;
    do_reset;
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
    total++; if (in_bits !== 8'h00) begin bad++; $display("FAIL reset_in_bits: got %h want 00", in_bits); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags: done=%b err=%b want 0 0", done, err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
  endtask

  task automatic test_start_end;
    int n05 = 0;
    rom_clear; rom[0] = 16'h000C; rom[2] = 16'h0014;
    do_reset; go = 1'b1;
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      tick;
      if (in_bits === 8'h05) n05++;
    end
    total++; if (n05 != 2) begin bad++; $display("FAIL start_len: got %0d cycles want 2", n05); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL end_done: got %b want 1", done); end
    total++; if (in_bits !== 8'h09) begin bad++; $display("FAIL end_in_bits: got %h want 09", in_bits); end
    total++; if (pc !== 8'h02) begin bad++; $display("FAIL end_pc: got %h want 02", pc); end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL end_status: busy=%b err=%b want 0 0", busy, err); end
    repeat (3) tick;
    total++; if (state_dbg !== S_DONE || done !== 1'b1 || in_bits !== 8'h09) begin
      bad++; $display("FAIL done_held: state=%0d done=%b in=%h want %0d 1 09", state_dbg, done, in_bits, S_DONE);
    end
  endtask

  task automatic test_get;
    logic [7:0] exp_in [7];
    logic [7:0] drv    [7];
    exp_in = '{8'h17, 8'h22, 8'h22, 8'h22, 8'h06, 8'h06, 8'h00};
    drv    = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h0C, 8'h0C};
    rom_clear; rom[0] = 16'h0501; rom[2] = 16'h0014;
    do_reset; go = 1'b1;
    tick; tick;
    for (int k = 0; k < 7; k++) begin
      tick;
      total++; if (in_bits !== exp_in[k]) begin bad++; $display("FAIL get_seq[%0d]: got %h want %h", k, in_bits, exp_in[k]); end
      out_bits = drv[k];
    end
    tick;
    out_bits = 8'h00;
    total++; if (pc !== 8'h02 || state_dbg !== S_FETCH) begin
      bad++; $display("FAIL get_advance: pc=%h state=%0d want 02 %0d", pc, state_dbg, S_FETCH);
    end
    for (int i = 0; i < 10 && done !== 1'b1; i++) tick;
    total++; if (done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL get_end: done=%b err=%b want 1 0", done, err); end
  endtask

  task automatic test_wait_cnt;
    int seg = 0;
    int len0 = 0;
    int len1 = 0;
    bit in_seg = 1'b0;
    rom_clear; rom[0] = 16'h0303; rom[2] = 16'h0003; rom[4] = 16'h0014;
    do_reset; go = 1'b1;
    for (int i = 0; i < 80 && done !== 1'b1; i++) begin
      tick;
      if (state_dbg === S_WAIT_CNT) begin
        if (!in_seg) seg++;
        in_seg = 1'b1;
        if (seg == 1) len0++;
        else if (seg == 2) len1++;
      end else begin
        in_seg = 1'b0;
      end
    end
    total++; if (len0 != 12) begin bad++; $display("FAIL wait3_len: got %0d want 12", len0); end
    total++; if (len1 != 1) begin bad++; $display("FAIL wait0_len: got %0d want 1", len1); end
    total++; if (done !== 1'b1 || pc !== 8'h04) begin bad++; $display("FAIL wait_end: done=%b pc=%h want 1 04", done, pc); end
  endtask

  task automatic test_timeout;
    int n = 0;
    rom_clear; rom[0] = 16'h006B; rom[2] = 16'h0014;
    do_reset; go = 1'b1;
    for (int i = 0; i < 40 && err !== 1'b1; i++) begin
      tick;
      if (state_dbg === S_WAIT_COND) n++;
    end
    total++; if (n != 10) begin bad++; $display("FAIL timeout_len: got %0d want 10", n); end
    total++; if (err !== 1'b1 || state_dbg !== S_ERROR) begin bad++; $display("FAIL timeout_err: err=%b state=%0d want 1 %0d", err, state_dbg, S_ERROR); end
    total++; if (in_bits !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL timeout_out: in=%h busy=%b done=%b want 00 0 0", in_bits, busy, done);
    end
    repeat (2) tick;
    total++; if (err !== 1'b1 || state_dbg !== S_ERROR) begin bad++; $display("FAIL error_held: err=%b state=%0d", err, state_dbg); end
  endtask

  task automatic test_cond_last_cycle;
    int n = 0;
    rom_clear; rom[0] = 16'h006B; rom[2] = 16'h0014;
    do_reset; go = 1'b1;
    for (int i = 0; i < 40 && done !== 1'b1 && err !== 1'b1; i++) begin
      tick;
      if (state_dbg === S_WAIT_COND) begin
        n++;
        if (n == 10) out_bits = 8'h20;
      end
    end
    out_bits = 8'h00;
    total++; if (n != 10) begin bad++; $display("FAIL cond_last_len: got %0d want 10", n); end
    total++; if (err !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL cond_last_wins: err=%b done=%b want 0 1", err, done); end
  endtask

  task automatic test_bad_opcode;
    rom_clear; rom[0] = 16'h008B;
    do_reset; go = 1'b1;
    for (int i = 0; i < 10 && err !== 1'b1; i++) tick;
    total++; if (err !== 1'b1 || done !== 1'b0 || pc !== 8'h00 || in_bits !== 8'h00) begin
      bad++; $display("FAIL bad_cond: err=%b done=%b pc=%h in=%h want 1 0 00 00", err, done, pc, in_bits);
    end
  endtask

  task automatic test_jump_wrap;
    rom_clear; rom[0] = 16'h7F02; rom[254] = 16'h0003;
    do_reset; go = 1'b1;
    for (int i = 0; i < 10 && pc !== 8'hFE; i++) tick;
    total++; if (pc !== 8'hFE) begin bad++; $display("FAIL jump_pc: got %h want fe", pc); end
    for (int i = 0; i < 20 && pc !== 8'h00; i++) tick;
    total++; if (pc !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL pc_wrap: pc=%h err=%b want 00 0", pc, err); end
  endtask

  task automatic test_step_mode;
    rom_clear; rom[0] = 16'h000C; rom[2] = 16'h000C; rom[4] = 16'h0014;
    do_reset; step_mode = 1'b1; go = 1'b1;
    for (int i = 0; i < 20 && state_dbg !== S_HOLD; i++) tick;
    total++; if (state_dbg !== S_HOLD || pc !== 8'h02 || in_bits !== 8'h00) begin
      bad++; $display("FAIL step_hold1: state=%0d pc=%h in=%h want %0d 02 00", state_dbg, pc, in_bits, S_HOLD);
    end
    repeat (4) tick;
    total++; if (state_dbg !== S_HOLD || pc !== 8'h02 || busy !== 1'b1) begin
      bad++; $display("FAIL step_stays: state=%0d pc=%h busy=%b want %0d 02 1", state_dbg, pc, busy, S_HOLD);
    end
    step = 1'b1; tick; step = 1'b0;
    total++; if (state_dbg !== S_FETCH || pc !== 8'h02) begin
      bad++; $display("FAIL step_pulse: state=%0d pc=%h want %0d 02", state_dbg, pc, S_FETCH);
    end
    for (int i = 0; i < 20 && state_dbg !== S_HOLD; i++) tick;
    total++; if (state_dbg !== S_HOLD || pc !== 8'h04) begin
      bad++; $display("FAIL step_hold2: state=%0d pc=%h want %0d 04", state_dbg, pc, S_HOLD);
    end
    step_mode = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick;
    total++; if (done !== 1'b1 || pc !== 8'h04) begin bad++; $display("FAIL step_release: done=%b pc=%h want 1 04", done, pc); end
  endtask

  task automatic test_rst_mid;
    rom_clear; rom[0] = 16'h000C; rom[2] = 16'h0501;
    do_reset; go = 1'b1;
    for (int i = 0; i < 30 && state_dbg !== S_MOVE; i++) tick;
    total++; if (state_dbg !== S_MOVE || pc !== 8'h02 || in_bits !== 8'h22) begin
      bad++; $display("FAIL rst_pre_move: state=%0d pc=%h in=%h want %0d 02 22", state_dbg, pc, in_bits, S_MOVE);
    end
    rst = 1'b1; go = 1'b0;
    tick;
    total++; if (state_dbg !== S_IDLE || pc !== 8'h00 || in_bits !== 8'h00 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_abort: state=%0d pc=%h in=%h busy=%b want 0 00 00 0", state_dbg, pc, in_bits, busy);
    end
    rst = 1'b0;
    tick;
    total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rst_idle_stays: state=%0d want 0", state_dbg); end
  endtask

  initial begin
    test_reset;
    test_start_end;
    test_get;
    test_wait_cnt;
    test_timeout;
    test_cond_last_cycle;
    test_bad_opcode;
    test_jump_wrap;
    test_step_mode;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
